riscv_register_file_mp: RTL and testbench



---
 rtl/riscv_register_file_mp.sv | 150 +++++++++++++++
 tb/tb_riscv_register_file_mp.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : riscv_register_file_mp                                            |
// | Multi-port flip-flop register file: N read / M write ports, highest write  |
// | port wins on collision, sequential clear engine. Optional same-cycle write |
// | forwarding to the read ports when RF_WRITE_FORWARD_EN is defined.          |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module riscv_register_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FP_BANK    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WPORTS-1:0]            we_i,
    input  logic                             clear_i,
    output logic                             busy_o,
    output logic                             collision_o
);

    localparam int                    c_NUM_WORDS  = 2**ADDR_WIDTH;
    localparam logic [0:0]            c_S_IDLE     = 1'b0;
    localparam logic [0:0]            c_S_CLEAR    = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_FIRST_WORD = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_WORD  = {ADDR_WIDTH{1'b1}};
    // With an FP bank the MSB is the bank select; only the integer bank's word 0 is hardwired.
    localparam logic [ADDR_WIDTH-1:0] c_INDEX_MASK =
        (FP_BANK != 0) ? ({ADDR_WIDTH{1'b1}} >> 1) : {ADDR_WIDTH{1'b1}};

    function automatic logic f_hardwired(input logic [ADDR_WIDTH-1:0] addr);
        f_hardwired = ((addr & c_INDEX_MASK) == '0) &&
                      !((FP_BANK != 0) && addr[ADDR_WIDTH-1]);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [c_NUM_WORDS];
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_ctr;
    logic                  r_collision;
    logic                  w_collision;
    logic                  w_clearing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (clear_i) w_state_next = c_S_CLEAR;
            c_S_CLEAR: if (!clear_i && (r_ctr == c_LAST_WORD)) w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_clearing = (r_state == c_S_CLEAR);
        busy_o     = w_clearing;
    end

    // A clear request restarts the sweep at word 1 whether idle or mid-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr <= '0;
        end else if (clear_i) begin
            r_ctr <= c_FIRST_WORD;
        end else if (w_clearing) begin
            r_ctr <= r_ctr + 1'b1;
        end
    end

    // Ascending port loop: the last non-blocking write, i.e. the highest port, wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < c_NUM_WORDS; w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_clearing) begin
            r_mem[r_ctr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p] && !f_hardwired(waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    r_mem[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_collision = 1'b0;
        for (int a = 0; a < NUM_WPORTS; a++) begin
            for (int b = a + 1; b < NUM_WPORTS; b++) begin
                if (we_i[a] && we_i[b] &&
                    (waddr_i[a*ADDR_WIDTH +: ADDR_WIDTH] == waddr_i[b*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    !f_hardwired(waddr_i[a*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    w_collision = 1'b1;
                end
            end
        end
        if (w_clearing) begin
            w_collision = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_collision;
        end
    end

    assign collision_o = r_collision;

    for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_rport
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0] w_rdata;

        assign w_raddr = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rdata = r_mem[w_raddr];
`ifdef RF_WRITE_FORWARD_EN
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p] && (waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == w_raddr)) begin
                    w_rdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
            if (w_clearing || f_hardwired(w_raddr)) begin
                w_rdata = '0;
            end
        end

        assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_riscv_register_file_mp                                         |
// | Scoreboard bench for riscv_register_file_mp against an array-based model.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_riscv_register_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int N  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata;
    logic [NW*AW-1:0] waddr = '0;
    logic [NW*DW-1:0] wdata = '0;
    logic [NW-1:0]    we = '0;
    logic             clear = 1'b0;
    logic             busy;
    logic             coll;

    logic [5:0]       fp_raddr = '0;
    logic [31:0]      fp_rdata;
    logic [5:0]       fp_waddr = '0;
    logic [31:0]      fp_wdata = '0;
    logic [0:0]       fp_we = '0;
    logic             fp_busy;
    logic             fp_coll;

    always #5 clk = ~clk;

    riscv_register_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
                             .NUM_WPORTS(NW), .FP_BANK(0)) dut (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata), .waddr_i(waddr),
        .wdata_i(wdata), .we_i(we), .clear_i(clear), .busy_o(busy), .collision_o(coll));

    riscv_register_file_mp #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RPORTS(1),
                             .NUM_WPORTS(1), .FP_BANK(1)) dut_fp (
        .clk(clk), .rst(rst), .raddr_i(fp_raddr), .rdata_o(fp_rdata), .waddr_i(fp_waddr),
        .wdata_i(fp_wdata), .we_i(fp_we), .clear_i(1'b0), .busy_o(fp_busy), .collision_o(fp_coll));

    typedef struct {
        int               kind;
        int               seq;
        logic [NR*DW-1:0] rdata;
        logic             busy;
        logic             coll;
        logic [31:0]      fp_rdata;
    } exp_t;

    exp_t q[$];
    event ev_sample;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    logic [31:0] m_mem [N];
    bit          m_busy;
    int          m_pos;
    bit          m_coll;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_busy = 0;
        m_pos  = 0;
        m_coll = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        logic [31:0] d;
        if (m_busy || a == 0) return '0;
        d = m_mem[a];
`ifdef RF_WRITE_FORWARD_EN
        for (int p = 0; p < NW; p++)
            if (we[p] && waddr[p*AW +: AW] == a) d = wdata[p*DW +: DW];
`endif
        return d;
    endfunction

    task automatic model_edge();
        int cnt [N];
        if (rst) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            m_mem[m_pos] = '0;
            m_coll = 0;
            if (clear) m_pos = 1;
            else if (m_pos == N - 1) begin m_busy = 0; m_pos = 0; end
            else m_pos++;
        end else begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int p = 0; p < NW; p++) if (we[p]) cnt[waddr[p*AW +: AW]]++;
            m_coll = 0;
            for (int i = 1; i < N; i++) if (cnt[i] >= 2) m_coll = 1;
            for (int p = 0; p < NW; p++)
                if (we[p] && waddr[p*AW +: AW] != 0) m_mem[waddr[p*AW +: AW]] = wdata[p*DW +: DW];
            if (clear) begin m_busy = 1; m_pos = 1; end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.kind = 0;
        e.seq  = seq++;
        for (int p = 0; p < NR; p++) e.rdata[p*DW +: DW] = m_read(raddr[p*AW +: AW]);
        e.busy = m_busy;
        e.coll = m_coll;
        e.fp_rdata = '0;
        q.push_back(e);
        -> ev_sample;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 push_exp();
        model_edge();
        @(posedge clk);
        #1 push_exp();
        @(negedge clk);
    endtask

    task automatic wport(input int p, input int a, input logic [31:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a += NR) begin
            for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = AW'((a + p) % N);
            step();
        end
    endtask

    task automatic fp_step(input logic [31:0] expv);
        exp_t e;
        @(posedge clk);
        #1;
        e.kind = 1;
        e.seq  = seq++;
        e.rdata = '0;
        e.busy = 1'b0;
        e.coll = 1'b0;
        e.fp_rdata = expv;
        q.push_back(e);
        -> ev_sample;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_sample);
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_empty: got sample with no expectation");
            end else begin
                e = q.pop_front();
                if (e.kind == 0) begin
                    for (int p = 0; p < NR; p++) begin
                        n_tests++;
                        if (rdata[p*DW +: DW] !== e.rdata[p*DW +: DW]) begin
                            n_fail++;
                            $display("FAIL rdata[%0d] seq %0d addr %0d: got %h expected %h", p, e.seq,
                                     raddr[p*AW +: AW], rdata[p*DW +: DW], e.rdata[p*DW +: DW]);
                        end
                    end
                    n_tests++;
                    if (busy !== e.busy) begin
                        n_fail++;
                        $display("FAIL busy seq %0d: got %b expected %b", e.seq, busy, e.busy);
                    end
                    n_tests++;
                    if (coll !== e.coll) begin
                        n_fail++;
                        $display("FAIL collision seq %0d: got %b expected %b", e.seq, coll, e.coll);
                    end
                end else begin
                    n_tests++;
                    if (fp_rdata !== e.fp_rdata || fp_busy !== 1'b0 || fp_coll !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fp_bank seq %0d: got %h/%b/%b expected %h/0/0", e.seq,
                                 fp_rdata, fp_busy, fp_coll, e.fp_rdata);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        read_all();

        // Distinct words on the two ports
        wport(0, 5, 32'hDEADBEEF);
        wport(1, 7, 32'h12345678);
        raddr = {AW'(0), AW'(7), AW'(5)};
        step();
        we = '0;
        step();

        // Same word: port 1 must win and flag a collision
        wport(0, 9, 32'h1);
        wport(1, 9, 32'h2);
        raddr = {AW'(9), AW'(9), AW'(9)};
        step();
        we = '0;
        step();
        wport(0, 0, 32'h1);
        wport(1, 0, 32'h2);
        raddr = '0;
        step();
        we = '0;
        step();

        // Same-cycle write/read of word 12
        wport(0, 12, 32'h11111111);
        step();
        wport(0, 12, 32'hCAFEF00D);
        raddr = {AW'(1), AW'(5), AW'(12)};
        step();
        we = '0;
        step();

        // Fill 1..31, then clear with a write attempted mid-clear
        for (int w = 1; w < N; w += 2) begin
            we = '0;
            wport(0, w, 32'h1000_0000 | w);
            if (w + 1 < N) wport(1, w + 1, 32'h2000_0000 | (w + 1));
            raddr = 15'($urandom);
            step();
        end
        we = '0;
        read_all();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) wport(0, 3, 32'hA5A5A5A5);
            else we = '0;
            raddr = 15'($urandom);
            step();
        end
        we = '0;
        read_all();

        // Restart at ctr 10, then asynchronous reset at ctr 20
        for (int w = 1; w < N; w++) begin
            we = '0;
            wport(1, w, $urandom | 32'h1);
            step();
        end
        we = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 9; i++) begin raddr = 15'($urandom); step(); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 19; i++) begin raddr = 15'($urandom); step(); end
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        read_all();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            raddr = 15'($urandom);
            we = 2'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                waddr[p*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wdata[p*DW +: DW] = $urandom;
            end
            clear = ($urandom_range(0, 39) == 0);
            step();
        end
        we = '0;
        clear = 1'b0;
        for (int i = 0; i < 35; i++) begin raddr = 15'($urandom); step(); end
        read_all();

        // FP bank: word 0 of the FP half (address 32) is writable, integer word 0 is not
        fp_we = 1'b1;
        fp_waddr = 6'd32;
        fp_wdata = 32'h3F800000;
        fp_raddr = 6'd32;
        fp_step(32'h3F800000);
        fp_waddr = 6'd0;
        fp_wdata = 32'hFFFFFFFF;
        fp_step(32'h3F800000);
        fp_we = 1'b0;
        fp_raddr = 6'd0;
        fp_step(32'h0);
        fp_raddr = 6'd32;
        fp_step(32'h3F800000);

        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
